// File: rtl/ram_fifo_ctrl.sv
// Single-clock FIFO controller driving an external simple dual-port RAM.
// A 4-entry output buffer hides the RAM read latency so the stream runs at one word per cycle.
module ram_fifo_ctrl #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter string OUTPUT_REG = "TRUE"
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int LAT = (OUTPUT_REG == "TRUE") ? 2 : 1;
  localparam int LW  = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   ram_used;
  logic [ADDR_WIDTH:0]   ram_used_nxt;
  logic [LAT-1:0]        rd_pipe;
  logic [LAT-1:0]        rd_pipe_nxt;
  logic [2:0]            inflight;
  logic [2:0]            inflight_nxt;
  logic [2:0]            obuf_count;
  logic [2:0]            obuf_count_nxt;
  logic [1:0]            obuf_head;
  logic [1:0]            obuf_tail;
  logic [DATA_WIDTH-1:0] obuf_mem [4];
  logic                  wr;
  logic                  rd;
  logic                  cap;
  logic                  pop;

  // Reads are only issued when the buffer is guaranteed room for every word already in flight.
  always_comb begin
    in_ready = (ram_used != DEPTH) && !rst;
    wr       = in_valid && in_ready;

    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + 3'(rd_pipe[i]);
    end

    rd        = (ram_used != '0) && ((inflight + obuf_count) < 3'd4) && !rst;
    cap       = rd_pipe[LAT-1];
    out_valid = (obuf_count != '0) && !rst;
    pop       = out_valid && out_ready;
    out_data  = obuf_mem[obuf_head];

    ram_we    = wr;
    ram_waddr = wptr;
    ram_wdata = in_data;
    ram_re    = rd;
    ram_raddr = rptr;

    ram_used_nxt = ram_used;
    if (wr && !rd) begin
      ram_used_nxt = ram_used + 1'b1;
    end else if (rd && !wr) begin
      ram_used_nxt = ram_used - 1'b1;
    end

    rd_pipe_nxt  = LAT'({rd_pipe, rd});
    inflight_nxt = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_nxt = inflight_nxt + 3'(rd_pipe_nxt[i]);
    end

    obuf_count_nxt = obuf_count + 3'(cap) - 3'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      ram_used   <= '0;
      rd_pipe    <= '0;
      obuf_count <= '0;
      obuf_head  <= '0;
      obuf_tail  <= '0;
      level      <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (rd) begin
        rptr <= rptr + 1'b1;
      end
      ram_used   <= ram_used_nxt;
      rd_pipe    <= rd_pipe_nxt;
      obuf_count <= obuf_count_nxt;
      if (cap) begin
        obuf_tail <= obuf_tail + 1'b1;
      end
      if (pop) begin
        obuf_head <= obuf_head + 1'b1;
      end
      level <= LW'(ram_used_nxt) + LW'(inflight_nxt) + LW'(obuf_count_nxt);
    end
  end

  // Buffer storage needs no reset: only entries counted by obuf_count are ever presented.
  always_ff @(posedge clk) begin
    if (cap) begin
      obuf_mem[obuf_tail] <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Testbench for ram_fifo_ctrl: two lanes (read latency 2 and 1) each with a RAM model and
// a queue-based reference model of the stream.
`timescale 1ns/1ps
module tb_ram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  typedef struct {
    logic [7:0] in_data;
    logic [7:0] exp_data;
    int         exp_extra;
    int         exp_level_after;
  } lat_vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_output(input string name, input int lane_l,
                              input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL L=%0d %s: got 0x%0h, expected 0x%0h", lane_l, name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int    L    = (g == 0) ? 2 : 1;
    localparam string OREG = (g == 0) ? "TRUE" : "FALSE";

    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW+1:0] level;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
    bit            done = 1'b0;

    ram_fifo_ctrl #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .OUTPUT_REG(OREG)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .level    (level),
      .ram_we   (ram_we),
      .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata),
      .ram_re   (ram_re),
      .ram_raddr(ram_raddr),
      .ram_rdata(ram_rdata)
    );

    // RAM model: read data is valid for exactly one cycle, L cycles after ram_re.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd0;
    logic [DW-1:0] rd1;
    logic [1:0]    rv = 2'b00;

    always @(posedge clk) begin
      if (ram_we) mem[ram_waddr] <= ram_wdata;
      rv  <= {rv[0], ram_re};
      rd0 <= mem[ram_raddr];
      rd1 <= rd0;
    end

    assign ram_rdata = (L == 1) ? (rv[0] ? rd0 : 8'hEE) : (rv[1] ? rd1 : 8'hEE);

    // Reference model: words accepted minus words popped, in order.
    logic [7:0] ref_q [$];
    int         exp_level = 0;
    int         pops = 0;
    bit         hold = 1'b0;
    logic [7:0] held;

    always @(negedge clk) begin
      if (rst) begin
        check_output("in_ready during reset", L, in_ready, 0);
        check_output("out_valid during reset", L, out_valid, 0);
        check_output("ram_we during reset", L, ram_we, 0);
        check_output("ram_re during reset", L, ram_re, 0);
        ref_q.delete();
        exp_level = 0;
        hold = 1'b0;
      end else begin
        check_output("level", L, level, exp_level);
        if (hold) begin
          check_output("stalled out_valid", L, out_valid, 1);
          check_output("stalled out_data", L, out_data, held);
        end
        if (ref_q.size() == 0) begin
          check_output("out_valid with empty model", L, out_valid, 0);
        end
        if (out_valid && out_ready && ref_q.size() > 0) begin
          check_output("out_data order", L, out_data, ref_q.pop_front());
          pops++;
          exp_level--;
        end
        if (in_valid && in_ready) begin
          ref_q.push_back(in_data);
          exp_level++;
        end
        hold = out_valid && !out_ready;
        held = out_data;
      end
    end

    task automatic step();
      @(posedge clk);
      #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [7:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
    endtask

    task automatic drain(input string name);
      int n = 0;
      apply_stimulus(1'b0, 8'h00, 1'b1);
      while ((ref_q.size() != 0 || level != 0) && n < 200) begin
        step();
        n++;
      end
      check_output({name, " drained level"}, L, level, 0);
      check_output({name, " drained model"}, L, ref_q.size(), 0);
      apply_stimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_out_valid(input string name, input logic [7:0] exp_data);
      int n = 0;
      bit seen = 1'b0;
      while (n < 20) begin
        @(negedge clk);
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
        step();
        n++;
      end
      check_output({name, " out_valid seen"}, L, seen, 1);
      check_output({name, " out_data"}, L, out_data, exp_data);
    endtask

    initial begin
      lat_vec_t vecs [4];
      int n;
      int acc;
      int sent;
      int gaps;
      int lat;
      int base;
      bit seen;

      vecs[0] = '{8'hA5, 8'hA5, 2, 0};
      vecs[1] = '{8'h00, 8'h00, 2, 0};
      vecs[2] = '{8'hFF, 8'hFF, 2, 0};
      vecs[3] = '{8'h3C, 8'h3C, 2, 0};

      rst = 1'b1;
      apply_stimulus(1'b0, 8'h00, 1'b0);
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      check_output("in_ready first cycle after reset", L, in_ready, 1);
      check_output("out_valid after reset", L, out_valid, 0);
      step();

      // Single-word latency into an empty block: first out_valid L+2 cycles after the write.
      for (int i = 0; i < 4; i++) begin
        apply_stimulus(1'b1, vecs[i].in_data, 1'b1);
        @(negedge clk);
        check_output("latency write accepted", L, in_ready, 1);
        step();
        apply_stimulus(1'b0, 8'h00, 1'b1);
        lat = 0;
        n = 1;
        while (n <= 20) begin
          @(negedge clk);
          if (out_valid) begin
            lat = n;
            check_output("latency out_data", L, out_data, vecs[i].exp_data);
            break;
          end
          step();
          n++;
        end
        check_output("first-word latency", L, lat, L + vecs[i].exp_extra);
        step();
        @(negedge clk);
        check_output("level after pop", L, level, vecs[i].exp_level_after);
        step();
      end

      // Fill with no consumer: 16 RAM words plus 4 buffered words.
      apply_stimulus(1'b1, 8'h00, 1'b0);
      acc = 0;
      n = 0;
      while (acc < 20 && n < 80) begin
        @(negedge clk);
        if (in_ready) acc++;
        step();
        n++;
        in_data = 8'(acc);
      end
      check_output("fill accepted", L, acc, 20);
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check_output("full in_ready", L, in_ready, 0);
        step();
      end
      @(negedge clk);
      check_output("full level", L, level, 20);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      check_output("full pop valid", L, out_valid, 1);
      check_output("full pop data", L, out_data, 8'h00);
      step();
      out_ready = 1'b0;
      @(negedge clk);
      check_output("full+issue in_ready", L, in_ready, 0);
      check_output("full+issue ram_re", L, ram_re, 1);
      check_output("full+issue ram_we", L, ram_we, 0);
      step();
      @(negedge clk);
      check_output("after issue in_ready", L, in_ready, 1);
      check_output("after issue ram_we", L, ram_we, 1);
      step();
      apply_stimulus(1'b0, 8'h00, 1'b0);
      drain("fill");

      // Streaming 100 words with both sides always ready.
      apply_stimulus(1'b1, 8'h00, 1'b1);
      sent = 0;
      base = pops;
      seen = 1'b0;
      gaps = 0;
      n = 0;
      while ((pops - base) < 100 && n < 400) begin
        @(negedge clk);
        if (in_valid && in_ready) sent++;
        if (seen && !out_valid) gaps++;
        if (out_valid) seen = 1'b1;
        step();
        n++;
        in_data = 8'(sent);
        if (sent == 100) in_valid = 1'b0;
      end
      check_output("stream words out", L, pops - base, 100);
      check_output("stream gaps", L, gaps, 0);
      drain("stream");

      // Random traffic with 30% consumer duty.
      for (int c = 0; c < 300; c++) begin
        apply_stimulus(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) < 3));
        step();
      end
      drain("backpressure");

      // Reset in the middle of traffic discards everything buffered or in flight.
      for (int c = 0; c < 5; c++) begin
        apply_stimulus(1'b1, 8'(8'h50 + c), 1'b0);
        step();
      end
      apply_stimulus(1'b0, 8'h00, 1'b1);
      wait_out_valid("pre-reset pop", 8'h50);
      step();
      out_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check_output("post-reset out_valid", L, out_valid, 0);
        check_output("post-reset level", L, level, 0);
        step();
      end
      apply_stimulus(1'b1, 8'h3C, 1'b1);
      step();
      apply_stimulus(1'b0, 8'h00, 1'b1);
      wait_out_valid("post-reset word", 8'h3C);
      step();
      drain("reset");

      done = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(lane[0].done && lane[1].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    if (!(lane[0].done && lane[1].done)) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL timeout: lanes done=%0d%0d, expected 11", lane[0].done, lane[1].done);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset. Port names: clk, rst.
REQ-002 Parameters SHALL be:
- DATA_WIDTH, default 8: word width.
- ADDR_WIDTH, default 9: RAM address width; DEPTH = 2**ADDR_WIDTH.
- OUTPUT_REG, default "TRUE": RAM read latency L, where "TRUE" gives L=2 and any other value gives L=1.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1: clock.
- rst, in, 1: synchronous active-high reset.
- in_valid, in, 1: write request.
- in_ready, out, 1: write accept.
- in_data, in, DATA_WIDTH: write word.
- out_valid, out, 1: read word available.
- out_ready, in, 1: consumer accepts.
- out_data, out, DATA_WIDTH: read word.
- level, out, ADDR_WIDTH+2: total words held.
- ram_we, out, 1: RAM write enable.
- ram_waddr, out, ADDR_WIDTH: RAM write address.
- ram_wdata, out, DATA_WIDTH: RAM write data.
- ram_re, out, 1: RAM read enable.
- ram_raddr, out, ADDR_WIDTH: RAM read address.
- ram_rdata, in, DATA_WIDTH: RAM read data; valid exactly L cycles after the ram_re cycle, and not held beyond that.

Function
REQ-004 The block SHALL be a single-clock FIFO controller driving an external simple dual-port RAM whose wclk and rclk both connect to clk, with a valid/ready stream on each side.
REQ-005 A write handshake SHALL occur in a cycle with in_valid=1 and in_ready=1.
- In that cycle: ram_we=1, ram_waddr=wptr, ram_wdata=in_data (combinational pass-through).
- wptr SHALL increment at the clock edge, wrapping modulo DEPTH.
REQ-006 in_ready SHALL equal (ram_used != DEPTH) and (rst == 0), where ram_used is a registered count of words written to RAM and not yet read-issued.
REQ-007 A read issue (ram_re=1, ram_raddr=rptr) SHALL occur in a cycle when both hold:
- ram_used > 0, and
- inflight + obuf_count < 4.
rptr SHALL then increment modulo DEPTH.
REQ-008 ram_used update per edge:
- +1 on a write only;
- -1 on a read issue only;
- unchanged when both occur or neither occurs.
REQ-009 An L-stage valid shift register SHALL track read issues. When the final stage is set, ram_rdata SHALL be captured into a 4-entry output buffer (obuf) at that edge.
REQ-010 inflight SHALL be the number of set bits in the shift register.
REQ-011 obuf SHALL never overflow; REQ-007 guarantees this by construction.
REQ-012 out_valid SHALL equal (obuf_count > 0).
- out_data SHALL be the obuf head word.
- A pop occurs when out_valid=1 and out_ready=1.
- out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-013 A capture and a pop in the same cycle SHALL leave obuf_count unchanged and preserve FIFO order.
REQ-014 First-word latency: a write handshake in cycle k into an entirely empty block SHALL give first out_valid=1 in cycle k+L+2.
REQ-015 With in_valid=1 and out_ready=1 held continuously, throughput SHALL be 1 word/cycle after the first word, with no bubbles, for both L=1 and L=2.
REQ-016 level SHALL equal ram_used + inflight + obuf_count, registered; its maximum is DEPTH+4.
REQ-017 Full: when ram_used = DEPTH, in_ready=0. A read issue in that cycle SHALL raise in_ready in the next cycle.
REQ-018 Empty: when ram_used = 0, ram_re SHALL stay 0, even if a write handshake occurs in the same cycle. The newly written word SHALL be read-issued no earlier than the next cycle.
REQ-019 Data order out SHALL equal data order in. No word SHALL be lost or duplicated across pointer wrap-around.

Reset
REQ-020 While rst=1, at every edge the block SHALL clear wptr, rptr, ram_used, the valid shift register, obuf_count and level to 0.
REQ-021 While rst=1, the block SHALL hold in_ready=0, ram_we=0, ram_re=0 and out_valid=0.
REQ-022 Reset asserted mid-operation SHALL discard all in-flight RAM reads and buffered words. No stale word SHALL appear on out_data with out_valid=1 after rst deasserts.
REQ-023 RAM contents SHALL NOT be cleared. Correctness SHALL rely only on the pointers.
REQ-024 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-025 The bench SHALL use ADDR_WIDTH=4 (DEPTH=16), DATA_WIDTH=8, and run each scenario below with both OUTPUT_REG settings:
- Latency: single write 0xA5 in cycle k, out_ready=1 -> out_valid first high in cycle k+L+2, out_data=0xA5, and level returns to 0 after the pop.
- Fill/full: out_ready=0, write 0x00..0x13 -> exactly 20 handshakes accepted (16 RAM + 4 obuf), then in_ready=0 and level=20. One pop -> in_ready=1 within 2 cycles, and the next write is accepted.
- Streaming/wrap: continuous in_valid=1 and out_ready=1 for 100 words 0..99 -> outputs 0..99 in order; after the first word, out_valid stays high with no gaps; pointers wrap 6 times.
- Backpressure: random out_ready at 30% duty with random in_valid -> scoreboard matches in order, and out_data stays stable whenever out_valid=1 and out_ready=0.
- Mid-reset: 5 words written, 1 popped, rst pulsed for 1 cycle -> out_valid=0 and level=0 afterwards. A new write of 0x3C is the next word out.
- Simultaneous at full: ram_used=16 with a read issue in the same cycle and in_valid=1 -> no write that cycle, a write the next cycle, and ram_used stays at most 16.
